// File: rtl/id_exe_issue.sv
// ID/EX issue stage: decodes an instruction, merges register and immediate
// operands, and registers the ALU command bundle with freeze/flush/bubble control.

module id_exe_issue_chk #(
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          freeze,
    input logic          hazard,
    input logic          issue_ready,
    input logic          exe_valid,
    input logic [3:0]    exe_cmd,
    input logic [DW-1:0] exe_val1,
    input logic          exe_wb,
    input logic          exe_mem_r,
    input logic          exe_mem_w,
    input logic [1:0]    exe_br,
    input logic          illegal
);

    a_bubble_quiet: assert property (@(posedge clk) disable iff (rst)
        !exe_valid |-> (!exe_wb && !exe_mem_r && !exe_mem_w && exe_br == 2'd0 && exe_cmd == 4'd0));

    a_mem_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(exe_mem_r && exe_mem_w));

    a_freeze_holds: assert property (@(posedge clk) disable iff (rst)
        freeze |=> ($stable(exe_valid) && $stable(exe_cmd) && $stable(exe_val1)));

    a_illegal_sticky: assert property (@(posedge clk) disable iff (rst)
        illegal |=> illegal);

    a_ready: assert property (@(posedge clk)
        issue_ready == (!freeze && !hazard));

endmodule

module id_exe_issue #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr,
    input  logic [31:0]   pc_in,
    input  logic          in_valid,
    input  logic [DW-1:0] reg_val1,
    input  logic [DW-1:0] reg_val2,
    input  logic          hazard,
    input  logic          freeze,
    input  logic          flush,
    output logic          issue_ready,
    output logic          exe_valid,
    output logic [3:0]    exe_cmd,
    output logic [DW-1:0] exe_val1,
    output logic [DW-1:0] exe_val2,
    output logic [DW-1:0] exe_st_val,
    output logic [RW-1:0] exe_dest,
    output logic          exe_mem_r,
    output logic          exe_mem_w,
    output logic          exe_wb,
    output logic [1:0]    exe_br,
    output logic [31:0]   exe_pc,
    output logic          illegal
);

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [DW-1:0] ZERO_DW = {DW{1'b0}};

    typedef struct packed {
        logic          valid;
        logic [3:0]    cmd;
        logic [DW-1:0] val1;
        logic [DW-1:0] val2;
        logic [DW-1:0] st_val;
        logic [RW-1:0] dest;
        logic          mem_r;
        logic          mem_w;
        logic          wb;
        logic [1:0]    br;
        logic [31:0]   pc;
    } bundle_t;

    localparam bundle_t BUBBLE = {$bits(bundle_t){1'b0}};

    logic [5:0]    opcode_s;
    logic [DW-1:0] imm_ext_s;
    logic [3:0]    dec_cmd_s;
    logic          dec_imm_s;
    logic          dec_wb_s;
    logic          dec_mem_r_s;
    logic          dec_mem_w_s;
    logic          dec_jmp_s;
    logic          dec_nop_s;
    logic          dec_undef_s;
    logic [1:0]    dec_br_s;
    logic          take_s;
    bundle_t       dec_s;
    bundle_t       next_s;
    bundle_t       exe_r;
    logic          flush_pend_r;
    logic          illegal_r;
    logic          unused_s;

    assign opcode_s  = instr[31:26];
    assign imm_ext_s = {{(DW-16){instr[15]}}, instr[15:0]};
    // src1 is consumed by the register file, not here
    assign unused_s  = ^instr[20:16];

    // A pending flush from a frozen cycle kills the next issue just like a live flush.
    assign take_s      = in_valid & ~hazard & ~flush & ~flush_pend_r;
    assign issue_ready = ~freeze & ~hazard;

    // Opcode decode into command and control flags.
    always_comb begin
        dec_cmd_s   = 4'b0000;
        dec_imm_s   = 1'b0;
        dec_wb_s    = 1'b0;
        dec_mem_r_s = 1'b0;
        dec_mem_w_s = 1'b0;
        dec_jmp_s   = 1'b0;
        dec_nop_s   = 1'b0;
        dec_undef_s = 1'b0;
        dec_br_s    = 2'd0;
        case (opcode_s)
            OP_ADD:  begin dec_cmd_s = 4'b0000; dec_wb_s = 1'b1; end
            OP_SUB:  begin dec_cmd_s = 4'b0010; dec_wb_s = 1'b1; end
            OP_AND:  begin dec_cmd_s = 4'b0100; dec_wb_s = 1'b1; end
            OP_OR:   begin dec_cmd_s = 4'b0101; dec_wb_s = 1'b1; end
            OP_NOR:  begin dec_cmd_s = 4'b0110; dec_wb_s = 1'b1; end
            OP_XOR:  begin dec_cmd_s = 4'b0111; dec_wb_s = 1'b1; end
            OP_SLA:  begin dec_cmd_s = 4'b1000; dec_wb_s = 1'b1; end
            OP_SLL:  begin dec_cmd_s = 4'b1000; dec_wb_s = 1'b1; end
            OP_SRA:  begin dec_cmd_s = 4'b1001; dec_wb_s = 1'b1; end
            OP_SRL:  begin dec_cmd_s = 4'b1010; dec_wb_s = 1'b1; end
            OP_ADDI: begin dec_cmd_s = 4'b0000; dec_imm_s = 1'b1; dec_wb_s = 1'b1; end
            OP_SUBI: begin dec_cmd_s = 4'b0010; dec_imm_s = 1'b1; dec_wb_s = 1'b1; end
            OP_LD:   begin dec_imm_s = 1'b1; dec_mem_r_s = 1'b1; dec_wb_s = 1'b1; end
            OP_ST:   begin dec_imm_s = 1'b1; dec_mem_w_s = 1'b1; end
            OP_BEZ:  begin dec_imm_s = 1'b1; dec_br_s = 2'd1; end
            OP_BNE:  begin dec_imm_s = 1'b1; dec_br_s = 2'd2; end
            OP_JMP:  begin dec_imm_s = 1'b1; dec_br_s = 2'd3; dec_jmp_s = 1'b1; end
            OP_NOP:  begin dec_nop_s = 1'b1; end
            default: begin dec_nop_s = 1'b1; dec_undef_s = 1'b1; end
        endcase
    end

    // Operand merge: NOPs carry no data; stores write back nothing and address with src2.
    always_comb begin
        dec_s       = BUBBLE;
        dec_s.valid = 1'b1;
        dec_s.cmd   = dec_cmd_s;
        dec_s.wb    = dec_wb_s;
        dec_s.mem_r = dec_mem_r_s;
        dec_s.mem_w = dec_mem_w_s;
        dec_s.br    = dec_br_s;
        dec_s.pc    = pc_in;
        if (dec_nop_s) begin
            dec_s.val1   = ZERO_DW;
            dec_s.val2   = ZERO_DW;
            dec_s.st_val = ZERO_DW;
            dec_s.dest   = {RW{1'b0}};
        end else begin
            if (dec_jmp_s) begin
                dec_s.val1 = ZERO_DW;
            end else begin
                dec_s.val1 = reg_val1;
            end
            if (dec_imm_s) begin
                dec_s.val2 = imm_ext_s;
            end else begin
                dec_s.val2 = reg_val2;
            end
            if (dec_mem_w_s) begin
                dec_s.dest   = instr[11 +: RW];
                dec_s.st_val = reg_val2;
            end else begin
                dec_s.dest   = instr[21 +: RW];
                dec_s.st_val = ZERO_DW;
            end
        end
    end

    // Select between the decoded bundle and a bubble.
    always_comb begin
        next_s = BUBBLE;
        if (take_s) begin
            next_s = dec_s;
        end else begin
            next_s = BUBBLE;
        end
    end

    // ID/EX pipeline register with freeze hold and one-deep flush memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_r        <= BUBBLE;
            flush_pend_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else if (freeze) begin
            exe_r        <= exe_r;
            flush_pend_r <= flush_pend_r | flush;
            illegal_r    <= illegal_r;
        end else begin
            exe_r        <= next_s;
            flush_pend_r <= 1'b0;
            illegal_r    <= illegal_r | (take_s & dec_undef_s);
        end
    end

    assign exe_valid  = exe_r.valid;
    assign exe_cmd    = exe_r.cmd;
    assign exe_val1   = exe_r.val1;
    assign exe_val2   = exe_r.val2;
    assign exe_st_val = exe_r.st_val;
    assign exe_dest   = exe_r.dest;
    assign exe_mem_r  = exe_r.mem_r;
    assign exe_mem_w  = exe_r.mem_w;
    assign exe_wb     = exe_r.wb;
    assign exe_br     = exe_r.br;
    assign exe_pc     = exe_r.pc;
    assign illegal    = illegal_r;

    id_exe_issue_chk #(.DW(DW)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .hazard      (hazard),
        .issue_ready (issue_ready),
        .exe_valid   (exe_valid),
        .exe_cmd     (exe_cmd),
        .exe_val1    (exe_val1),
        .exe_wb      (exe_wb),
        .exe_mem_r   (exe_mem_r),
        .exe_mem_w   (exe_mem_w),
        .exe_br      (exe_br),
        .illegal     (illegal)
    );

endmodule

// File: tb/tb_id_exe_issue.sv
// Bench for id_exe_issue: directed vector table, freeze/flush sequences,
// and random stimulus against an opcode-table reference model.

module tb_id_exe_issue;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        in_valid;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        hazard;
        logic        freeze;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cmd;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] st_val;
        logic [4:0]  dest;
        logic        mem_r;
        logic        mem_w;
        logic        wb;
        logic [1:0]  br;
        logic [31:0] pc;
        logic        illegal;
    } out_t;

    typedef struct packed {
        in_t  inp;
        out_t want;
        logic rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, hazard, freeze, flush;
    logic [31:0] instr, pc_in, reg_val1, reg_val2;
    logic        issue_ready, exe_valid, exe_mem_r, exe_mem_w, exe_wb, illegal;
    logic [3:0]  exe_cmd;
    logic [31:0] exe_val1, exe_val2, exe_st_val, exe_pc;
    logic [4:0]  exe_dest;
    logic [1:0]  exe_br;

    int total = 0;
    int bad   = 0;
    int cmd_of[64];
    vec_t tbl[$];

    always #5 clk = ~clk;

    id_exe_issue dut (
        .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in), .in_valid(in_valid),
        .reg_val1(reg_val1), .reg_val2(reg_val2), .hazard(hazard), .freeze(freeze),
        .flush(flush), .issue_ready(issue_ready), .exe_valid(exe_valid), .exe_cmd(exe_cmd),
        .exe_val1(exe_val1), .exe_val2(exe_val2), .exe_st_val(exe_st_val), .exe_dest(exe_dest),
        .exe_mem_r(exe_mem_r), .exe_mem_w(exe_mem_w), .exe_wb(exe_wb), .exe_br(exe_br),
        .exe_pc(exe_pc), .illegal(illegal)
    );

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] d, logic [4:0] s1, logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    function automatic in_t mi(logic r, logic [31:0] ins, logic [31:0] pc, logic iv,
                               logic [31:0] v1, logic [31:0] v2, logic hz, logic fr, logic fl);
        in_t x;
        x.rst = r; x.instr = ins; x.pc = pc; x.in_valid = iv; x.v1 = v1; x.v2 = v2;
        x.hazard = hz; x.freeze = fr; x.flush = fl;
        return x;
    endfunction

    function automatic out_t mko(logic v, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] s, logic [4:0] d, logic mr, logic mw, logic wb,
                                 logic [1:0] br, logic [31:0] pc, logic il);
        out_t o;
        o.valid = v; o.cmd = c; o.val1 = a; o.val2 = b; o.st_val = s; o.dest = d;
        o.mem_r = mr; o.mem_w = mw; o.wb = wb; o.br = br; o.pc = pc; o.illegal = il;
        return o;
    endfunction

    function automatic vec_t vv(in_t a, out_t b, logic r);
        vec_t x;
        x.inp = a; x.want = b; x.rdy = r;
        return x;
    endfunction

    // Reference decode straight from the opcode table.
    function automatic out_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] v1, logic [31:0] v2);
        out_t r;
        int op;
        r = '0;
        op = int'(ins[31:26]);
        r.valid = 1'b1;
        r.pc = pc;
        if (cmd_of[op] < 0) return r;
        r.cmd    = 4'(cmd_of[op]);
        r.val1   = (op == 42) ? 32'd0 : v1;
        r.val2   = (op < 32) ? v2 : {{16{ins[15]}}, ins[15:0]};
        r.dest   = (op == 37) ? ins[15:11] : ins[25:21];
        r.st_val = (op == 37) ? v2 : 32'd0;
        r.wb     = (op < 32) || (op == 32) || (op == 33) || (op == 36);
        r.mem_r  = (op == 36);
        r.mem_w  = (op == 37);
        r.br     = (op == 40) ? 2'd1 : (op == 41) ? 2'd2 : (op == 42) ? 2'd3 : 2'd0;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic check_all(string tag, out_t e);
        chk({tag, ".valid"},   32'(exe_valid),  32'(e.valid));
        chk({tag, ".cmd"},     32'(exe_cmd),    32'(e.cmd));
        chk({tag, ".val1"},    exe_val1,        e.val1);
        chk({tag, ".val2"},    exe_val2,        e.val2);
        chk({tag, ".st_val"},  exe_st_val,      e.st_val);
        chk({tag, ".dest"},    32'(exe_dest),   32'(e.dest));
        chk({tag, ".mem_r"},   32'(exe_mem_r),  32'(e.mem_r));
        chk({tag, ".mem_w"},   32'(exe_mem_w),  32'(e.mem_w));
        chk({tag, ".wb"},      32'(exe_wb),     32'(e.wb));
        chk({tag, ".br"},      32'(exe_br),     32'(e.br));
        chk({tag, ".pc"},      exe_pc,          e.pc);
        chk({tag, ".illegal"}, 32'(illegal),    32'(e.illegal));
    endtask

    task automatic apply(in_t v, logic exp_ready, string tag);
        @(negedge clk);
        rst = v.rst; instr = v.instr; pc_in = v.pc; in_valid = v.in_valid;
        reg_val1 = v.v1; reg_val2 = v.v2; hazard = v.hazard; freeze = v.freeze; flush = v.flush;
        #1;
        chk({tag, ".ready"}, 32'(issue_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        out_t ld_o, zero_o, m;
        in_t  r;
        bit   pend, ill;
        int   op;
        logic [31:0] tmp;
        int   legal[18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

        foreach (cmd_of[k]) cmd_of[k] = -1;
        cmd_of[1] = 0;  cmd_of[3] = 2;  cmd_of[5] = 4;  cmd_of[6] = 5;  cmd_of[7] = 6;
        cmd_of[8] = 7;  cmd_of[9] = 8;  cmd_of[10] = 8; cmd_of[11] = 9; cmd_of[12] = 10;
        cmd_of[32] = 0; cmd_of[33] = 2; cmd_of[36] = 0; cmd_of[37] = 0;
        cmd_of[40] = 0; cmd_of[41] = 0; cmd_of[42] = 0;

        rst = 1'b1; instr = 32'd0; pc_in = 32'd0; in_valid = 1'b0; reg_val1 = 32'd0;
        reg_val2 = 32'd0; hazard = 1'b0; freeze = 1'b0; flush = 1'b0;
        zero_o = '0;

        tbl.push_back(vv(mi(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0), zero_o, 1'b1));
        tbl.push_back(vv(mi(1'b1, $urandom(), $urandom(), 1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1), zero_o, 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd1, 5'd3, 5'd1, {5'd2, 11'd0}), 32'h104, 1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 2'd0, 32'h104, 1'b0), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd32, 5'd4, 5'd1, 16'hFFFC), 32'h108, 1'b1, 32'd10, 32'd99, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'd10, 32'hFFFFFFFC, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1, 2'd0, 32'h108, 1'b0), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd11, 5'd5, 5'd1, {5'd2, 11'd0}), 32'h10C, 1'b1, 32'h80000000, 32'd4, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b1001, 32'h80000000, 32'd4, 32'd0, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10C, 1'b0), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd3, 5'd6, 5'd1, {5'd2, 11'd0}), 32'h110, 1'b1, 32'd9, 32'd3, 1'b1, 1'b0, 1'b0),
                         zero_o, 1'b0));
        tbl.push_back(vv(mi(1'b0, mk(6'd3, 5'd6, 5'd1, {5'd2, 11'd0}), 32'h110, 1'b1, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0010, 32'd9, 32'd3, 32'd0, 5'd6, 1'b0, 1'b0, 1'b1, 2'd0, 32'h110, 1'b0), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd50, 5'd7, 5'd1, 16'h1234), 32'h114, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h114, 1'b1), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd37, 5'd9, 5'd1, 16'h2010), 32'h118, 1'b1, 32'h100, 32'h55, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'h100, 32'h2010, 32'h55, 5'd4, 1'b0, 1'b1, 1'b0, 2'd0, 32'h118, 1'b1), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd1, 5'd3, 5'd1, 16'h0), 32'h11C, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0),
                         mko(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd42, 5'd0, 5'd0, 16'h8000), 32'h120, 1'b1, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'd0, 32'hFFFF8000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h120, 1'b1), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd36, 5'd8, 5'd2, 16'h0004), 32'h124, 1'b1, 32'h200, 32'd6, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'h200, 32'd4, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 2'd0, 32'h124, 1'b1), 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd1, 5'd3, 5'd1, 16'h0), 32'h128, 1'b1, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1),
                         mko(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1), 1'b0));
        tbl.push_back(vv(mi(1'b0, mk(6'd41, 5'd2, 5'd3, 16'h0010), 32'h12C, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0000, 32'd1, 32'h10, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0, 2'd2, 32'h12C, 1'b1), 1'b1));
        tbl.push_back(vv(mi(1'b1, mk(6'd1, 5'd3, 5'd1, 16'h0), 32'h130, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0),
                         zero_o, 1'b1));
        tbl.push_back(vv(mi(1'b0, mk(6'd8, 5'd1, 5'd2, {5'd3, 11'd0}), 32'h134, 1'b1, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0, 1'b0),
                         mko(1'b1, 4'b0111, 32'hF0F0, 32'h0FF0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h134, 1'b0), 1'b1));

        foreach (tbl[k]) begin
            apply(tbl[k].inp, tbl[k].rdy, $sformatf("v%0d", k));
            check_all($sformatf("v%0d", k), tbl[k].want);
        end

        // Freeze holds a registered LD while the input keeps changing.
        ld_o = mko(1'b1, 4'b0000, 32'h40, 32'h8, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 2'd0, 32'h200, 1'b0);
        apply(mi(1'b0, mk(6'd36, 5'd6, 5'd1, 16'h0008), 32'h200, 1'b1, 32'h40, 32'h9, 1'b0, 1'b0, 1'b0), 1'b1, "ld");
        check_all("ld", ld_o);
        for (int k = 0; k < 3; k++) begin
            apply(mi(1'b0, mk(6'd1, 5'(k), 5'd1, 16'h0), 32'h204 + 32'(k), 1'b1, $urandom(), $urandom(),
                     1'b0, 1'b1, 1'b0), 1'b0, "frz");
            check_all($sformatf("frz%0d", k), ld_o);
        end
        // Flush pulsed mid-freeze: one bubble after unfreeze, then the new instruction.
        for (int k = 0; k < 3; k++) begin
            apply(mi(1'b0, mk(6'd5, 5'd2, 5'd1, 16'h0), 32'h210, 1'b1, 32'd3, 32'd4,
                     1'b0, 1'b1, (k == 1)), 1'b0, "frzfl");
            check_all($sformatf("frzfl%0d", k), ld_o);
        end
        apply(mi(1'b0, mk(6'd1, 5'd3, 5'd1, {5'd2, 11'd0}), 32'h300, 1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0), 1'b1, "pend");
        check_all("pend", zero_o);
        apply(mi(1'b0, mk(6'd3, 5'd4, 5'd1, {5'd2, 11'd0}), 32'h304, 1'b1, 32'd20, 32'd8, 1'b0, 1'b0, 1'b0), 1'b1, "after");
        check_all("after", mko(1'b1, 4'b0010, 32'd20, 32'd8, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1, 2'd0, 32'h304, 1'b0));
        // Two flushes in one freeze coalesce into a single bubble.
        for (int k = 0; k < 2; k++) begin
            apply(mi(1'b0, mk(6'd1, 5'd1, 5'd1, 16'h0), 32'h308, 1'b1, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1), 1'b0, "co");
        end
        apply(mi(1'b0, mk(6'd6, 5'd7, 5'd1, 16'h0), 32'h30C, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0), 1'b1, "co_b");
        check_all("co_b", zero_o);
        apply(mi(1'b0, mk(6'd6, 5'd7, 5'd1, 16'h0), 32'h310, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0), 1'b1, "co_l");
        check_all("co_l", mko(1'b1, 4'b0101, 32'd1, 32'd2, 32'd0, 5'd7, 1'b0, 1'b0, 1'b1, 2'd0, 32'h310, 1'b0));

        // Random stimulus against the reference model.
        m = '0; pend = 1'b0; ill = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(9, 0) == 0) op = int'($urandom_range(63, 0));
            else op = legal[$urandom_range(17, 0)];
            tmp = $urandom();
            r.rst      = (n == 0) || ($urandom_range(49, 0) == 0);
            r.instr    = {6'(op), tmp[25:0]};
            r.pc       = $urandom();
            r.in_valid = ($urandom_range(9, 0) != 0);
            r.v1       = $urandom();
            r.v2       = $urandom();
            r.hazard   = ($urandom_range(6, 0) == 0);
            r.freeze   = ($urandom_range(4, 0) == 0);
            r.flush    = ($urandom_range(7, 0) == 0);
            if (r.rst) begin
                m = '0; pend = 1'b0; ill = 1'b0;
            end else if (r.freeze) begin
                if (r.flush) pend = 1'b1;
            end else if (r.flush || pend) begin
                m = '0; pend = 1'b0;
            end else if (r.hazard || !r.in_valid) begin
                m = '0;
            end else begin
                m = ref_decode(r.instr, r.pc, r.v1, r.v2);
                if (cmd_of[op] < 0 && op != 0) ill = 1'b1;
            end
            m.illegal = ill;
            apply(r, !(r.freeze || r.hazard), "rnd");
            check_all($sformatf("rnd%0d", n), m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_issue.md
Name: id_exe_issue

Overview:
- Instruction-decode and issue stage that produces the operand/command bundle consumed by the execute-stage ALU (in1, in2, 4-bit cmd).
- Decodes a 32-bit instruction and merges it with register-file read data and the immediate.
- Holds the result in the ID/EX pipeline register, with freeze (cache miss), flush (taken branch) and hazard-bubble control.
- Sits between the register file / hazard unit and the EXE stage of the cached MIPS pipeline.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  fetched instruction: [31:26] opcode, [25:21] dest, [20:16] src1, [15:11] src2, [15:0] imm.
- pc_in  in  32  PC+4 of instr.
- in_valid  in  1  instr/pc_in/reg data valid this cycle.
- reg_val1  in  DW  regfile read of src1.
- reg_val2  in  DW  regfile read of src2.
- hazard  in  1  data hazard detected; insert bubble, hold upstream.
- freeze  in  1  memory stage stalled (cache miss); hold the ID/EX register.
- flush  in  1  taken branch in EXE; kill the instruction being issued.
- issue_ready  out  1  upstream may advance = ~freeze & ~hazard.
- exe_valid  out  1  ID/EX register holds a live instruction.
- exe_cmd  out  4  ALU command.
- exe_val1  out  DW  ALU in1.
- exe_val2  out  DW  ALU in2.
- exe_st_val  out  DW  store data (reg_val2 for ST).
- exe_dest  out  RW  writeback register.
- exe_mem_r  out  1  load.
- exe_mem_w  out  1  store.
- exe_wb  out  1  register writeback enable.
- exe_br  out  2  0 none, 1 BEZ, 2 BNE, 3 JMP.
- exe_pc  out  32  pc_in passthrough.
- illegal  out  1  sticky: an undefined opcode was issued.

Behaviour:
- Decode table (opcode -> cmd, val2 source, wb/mem/br):
  - ADD=1 -> 0000, reg
  - SUB=3 -> 0010, reg
  - AND=5 -> 0100, reg
  - OR=6 -> 0101, reg
  - NOR=7 -> 0110, reg
  - XOR=8 -> 0111, reg
  - SLA=9 and SLL=10 -> 1000, reg
  - SRA=11 -> 1001, reg
  - SRL=12 -> 1010, reg
  - All of the above: wb=1.
  - ADDI=32 -> 0000, imm, wb=1.
  - SUBI=33 -> 0010, imm, wb=1.
  - LD=36 -> 0000, imm, mem_r=1, wb=1.
  - ST=37 -> 0000, imm, mem_w=1, st_val=reg_val2, dest=src2.
  - BEZ=40 -> 0000, imm, br=1.
  - BNE=41 -> 0000, imm, br=2.
  - JMP=42 -> 0000, imm, br=3, val1=0.
  - opcode 0 -> NOP: valid issue, all enables 0, cmd 0000.
  - Any other opcode -> NOP and set illegal.
- Immediate is sign-extended from imm[15] to DW. Shift amount is the full reg_val2; no truncation here.
- Latency: one cycle. Inputs sampled at edge N appear on exe_* after edge N.
- Register update per rising edge, priority rst > freeze > flush > hazard > load.
  - rst: all outputs 0 (exe_cmd=0000, exe_valid=0, illegal=0); flush_pend=0.
  - freeze: every exe_* holds its value. If flush=1 during freeze, set flush_pend.
  - flush or flush_pend (no freeze): load bubble (exe_valid=0, wb/mem_r/mem_w/br=0, data fields 0); clear flush_pend.
  - hazard (no freeze/flush): load bubble; upstream holds because issue_ready=0.
  - load: if in_valid, load the decoded bundle with exe_valid=1; otherwise load a bubble.
- Flush at the same edge as hazard or in_valid: flush wins and the instruction is dropped.
- flush_pend is a single bit. Repeated flushes during one freeze coalesce into one bubble.
- illegal sets only on an actual load of an undefined opcode, never on a bubble or held cycle. It clears only on rst.
- issue_ready is combinational from freeze and hazard.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all exe_* = 0, exe_valid=0, illegal=0.
- Load: instr ADD dest=3 src1=1 src2=2, reg_val1=5, reg_val2=7 -> next cycle exe_cmd=0000, val1=5, val2=7, dest=3, wb=1, valid=1.
- Immediate: ADDI imm=0xFFFC, reg_val1=10 -> val2=0xFFFFFFFC, cmd=0000. SRA with reg_val2=4 -> cmd=1001, val2=4.
- Freeze: freeze=1 for 3 cycles with an LD registered, instr changing -> outputs unchanged, issue_ready=0. Freeze with flush pulsed in cycle 2 -> first unfrozen edge loads a bubble, and the next edge loads the new instruction.
- Bubble: hazard=1 with SUB on input -> exe_valid=0, wb=0, issue_ready=0. Hazard dropped -> SUB issues with cmd=0010.
- Illegal: opcode 50 issued -> NOP bundle with valid=1 and illegal=1, and illegal stays set after later legal instructions until rst. ST src2=4 reg_val2=0x55 -> mem_w=1, st_val=0x55, wb=0.
